// File: rtl/id_issue_sequencer_if.sv
// Decoder-to-sequencer instruction-ID handshake.
// The master is the front-end decoder and the slave is the issue sequencer.
interface id_issue_sequencer_if;
    logic [6:0] decoded_id;
    logic       id_valid;
    logic       id_ready;

    modport master (
        output decoded_id,
        output id_valid,
        input  id_ready
    );

    modport slave (
        input  decoded_id,
        input  id_valid,
        output id_ready
    );
endinterface

// File: rtl/id_issue_sequencer.sv
// Issues classified instruction IDs to the control core and holds each one
// for the cycles it needs: reset hold, single-cycle ops, memory waits and halt.
module id_issue_sequencer #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned NOP_ID       = 35,
    parameter int unsigned RESET_ID     = 100,
    parameter int unsigned HALT_ID      = 75
) (
    input  logic                 clock,
    input  logic                 reset,
    id_issue_sequencer_if.slave  dec,
    input  logic                 mem_done,
    input  logic                 wake,
    output logic [6:0]           ID,
    output logic                 take,
    output logic                 fault,
    output logic                 halted
);

    localparam int unsigned CMAX =
        (RESET_CYCLES > MEM_TIMEOUT) ? RESET_CYCLES : MEM_TIMEOUT;
    localparam int CW = $clog2(CMAX + 1);

    localparam logic [6:0] NOP = 7'(NOP_ID);
    localparam logic [6:0] RST = 7'(RESET_ID);
    localparam logic [6:0] HLT = 7'(HALT_ID);

    localparam logic [CW-1:0] RST_LOAD = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] MEM_LOAD = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RST,
        S_IDLE,
        S_MEM,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_SINGLE,
        C_MEM,
        C_HALT,
        C_RESET,
        C_ILLEGAL
    } cls_t;

    state_t        state;
    cls_t          cls;
    logic [CW-1:0] cnt;
    logic          ready_q;
    logic          accept;

    assign dec.id_ready = ready_q;
    assign accept       = dec.id_valid & ready_q;

    // Reset and halt IDs are parameters, so they are matched before the fixed tables.
    always_comb begin
        cls = C_ILLEGAL;
        if (dec.decoded_id == RST)
            cls = C_RESET;
        else if (dec.decoded_id == HLT)
            cls = C_HALT;
        else if (dec.decoded_id inside {[7'd39:7'd55], 7'd67, 7'd68, 7'd71})
            cls = C_MEM;
        else if (dec.decoded_id inside {[7'd1:7'd38], [7'd56:7'd66],
                                        7'd69, 7'd70, [7'd72:7'd74]})
            cls = C_SINGLE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= S_RST;
            ID      <= RST;
            cnt     <= RST_LOAD;
            ready_q <= 1'b0;
            take    <= 1'b0;
            fault   <= 1'b0;
            halted  <= 1'b0;
        end else begin
            take  <= 1'b0;
            fault <= 1'b0;
            unique case (state)
                S_RST: begin
                    if (cnt == '0) begin
                        state   <= S_IDLE;
                        ID      <= NOP;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!accept) begin
                        ID <= NOP;
                    end else begin
                        unique case (cls)
                            C_SINGLE: begin
                                ID   <= dec.decoded_id;
                                take <= 1'b1;
                            end
                            C_MEM: begin
                                ID      <= dec.decoded_id;
                                ready_q <= 1'b0;
                                cnt     <= MEM_LOAD;
                                state   <= S_MEM;
                            end
                            C_HALT: begin
                                ID      <= HLT;
                                halted  <= 1'b1;
                                ready_q <= 1'b0;
                                state   <= S_HALT;
                            end
                            C_RESET: begin
                                ID      <= RST;
                                cnt     <= RST_LOAD;
                                ready_q <= 1'b0;
                                state   <= S_RST;
                            end
                            C_ILLEGAL: begin
                                ID    <= 7'd0;
                                fault <= 1'b1;
                            end
                        endcase
                    end
                end
                // Completion beats timeout when both land on the same edge.
                S_MEM: begin
                    if (mem_done) begin
                        take    <= 1'b1;
                        ready_q <= 1'b1;
                        state   <= S_IDLE;
                    end else if (cnt == '0) begin
                        ID      <= NOP;
                        fault   <= 1'b1;
                        ready_q <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HALT: begin
                    if (wake) begin
                        ID      <= NOP;
                        halted  <= 1'b0;
                        take    <= 1'b1;
                        ready_q <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_issue_sequencer.sv
// Directed and randomized bench for id_issue_sequencer, checked every cycle
// against a behavioural model of the issue rules.
module tb_id_issue_sequencer;

    localparam int RESET_CYCLES = 2;
    localparam int MEM_TIMEOUT  = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mem_done = 1'b0;
    logic       wake = 1'b0;
    logic [6:0] ID;
    logic       take;
    logic       fault;
    logic       halted;

    int checks = 0;
    int errors = 0;

    id_issue_sequencer_if dec_if ();

    id_issue_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .dec      (dec_if.slave),
        .mem_done (mem_done),
        .wake     (wake),
        .ID       (ID),
        .take     (take),
        .fault    (fault),
        .halted   (halted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction classes as listed in the ID map.
    typedef enum int { K_SINGLE, K_MEM, K_HALT, K_RESET, K_ILLEGAL } kind_t;

    function automatic kind_t kind_of(input int id);
        if (id == 100) return K_RESET;
        if (id == 75) return K_HALT;
        if (id inside {[39:55], 67, 68, 71}) return K_MEM;
        if (id inside {[1:38], [56:66], 69, 70, [72:74]}) return K_SINGLE;
        return K_ILLEGAL;
    endfunction

    // Model: remaining reset-hold cycles, memory wait age, halt flag.
    bit m_valid = 0;
    int m_rst_left = 0;
    bit m_mem = 0;
    int m_age = 0;
    bit m_halt = 0;
    int e_id = 0;
    bit e_take = 0;
    bit e_fault = 0;
    bit e_ready = 0;

    always @(posedge clock) begin
        e_take  = 0;
        e_fault = 0;
        if (!reset) begin
            m_valid    = 1;
            m_rst_left = RESET_CYCLES;
            m_mem      = 0;
            m_halt     = 0;
            e_id       = 100;
            e_ready    = 0;
        end else if (m_rst_left > 0) begin
            m_rst_left--;
            if (m_rst_left == 0) begin
                e_id    = 35;
                e_ready = 1;
            end
        end else if (m_mem) begin
            if (mem_done) begin
                e_take  = 1;
                e_ready = 1;
                m_mem   = 0;
            end else begin
                m_age++;
                if (m_age == MEM_TIMEOUT) begin
                    e_id    = 35;
                    e_fault = 1;
                    e_ready = 1;
                    m_mem   = 0;
                end
            end
        end else if (m_halt) begin
            if (wake) begin
                m_halt  = 0;
                e_id    = 35;
                e_take  = 1;
                e_ready = 1;
            end
        end else if (dec_if.id_valid) begin
            case (kind_of(int'(dec_if.decoded_id)))
                K_SINGLE: begin
                    e_id   = int'(dec_if.decoded_id);
                    e_take = 1;
                end
                K_MEM: begin
                    e_id    = int'(dec_if.decoded_id);
                    e_ready = 0;
                    m_mem   = 1;
                    m_age   = 0;
                end
                K_HALT: begin
                    e_id    = 75;
                    e_ready = 0;
                    m_halt  = 1;
                end
                K_RESET: begin
                    e_id       = 100;
                    e_ready    = 0;
                    m_rst_left = RESET_CYCLES;
                end
                default: begin
                    e_id    = 0;
                    e_fault = 1;
                end
            endcase
        end else begin
            e_id = 35;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            chk("model_ID", int'(ID), e_id);
            chk("model_take", int'(take), int'(e_take));
            chk("model_fault", int'(fault), int'(e_fault));
            chk("model_halted", int'(halted), int'(m_halt));
            chk("model_ready", int'(dec_if.id_ready), int'(e_ready));
            chk("take_fault_excl", int'(take & fault), 0);
        end
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic issue(input int id);
        dec_if.id_valid   = 1'b1;
        dec_if.decoded_id = 7'(id);
        cyc();
        dec_if.id_valid   = 1'b0;
    endtask

    initial begin
        dec_if.id_valid   = 1'b0;
        dec_if.decoded_id = 7'd0;

        // T1 reset hold
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        chk("t1_hold_id", int'(ID), 100);
        chk("t1_hold_ready", int'(dec_if.id_ready), 0);
        cyc();
        chk("t1_idle_id", int'(ID), 35);
        chk("t1_idle_ready", int'(dec_if.id_ready), 1);
        chk("t1_idle_take", int'(take), 0);

        // T2 back-to-back singles
        dec_if.id_valid = 1'b1;
        dec_if.decoded_id = 7'd4;
        cyc();
        chk("t2_id4", int'(ID), 4);
        chk("t2_take4", int'(take), 1);
        dec_if.decoded_id = 7'd17;
        cyc();
        chk("t2_id17", int'(ID), 17);
        chk("t2_take17", int'(take), 1);
        dec_if.decoded_id = 7'd56;
        cyc();
        chk("t2_id56", int'(ID), 56);
        chk("t2_take56", int'(take), 1);
        dec_if.id_valid = 1'b0;
        cyc();
        chk("t2_nop", int'(ID), 35);

        // T3 load completes, next op follows with no bubble
        issue(44);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_id", int'(ID), 44);
            chk("t3_hold_take", int'(take), 0);
            if (i == 2) mem_done = 1'b1;
            cyc();
        end
        mem_done = 1'b0;
        chk("t3_done_id", int'(ID), 44);
        chk("t3_done_take", int'(take), 1);
        issue(20);
        chk("t3_next_id", int'(ID), 20);
        chk("t3_next_take", int'(take), 1);

        // T4 timeout
        issue(40);
        for (int i = 0; i < 16; i++) begin
            chk("t4_wait_id", int'(ID), 40);
            chk("t4_wait_fault", int'(fault), 0);
            cyc();
        end
        chk("t4_to_id", int'(ID), 35);
        chk("t4_to_fault", int'(fault), 1);
        chk("t4_to_take", int'(take), 0);
        cyc();
        chk("t4_fault_pulse", int'(fault), 0);

        // T5 halt, with a decoder request that must be ignored
        issue(75);
        dec_if.id_valid = 1'b1;
        dec_if.decoded_id = 7'd5;
        for (int i = 0; i < 10; i++) begin
            chk("t5_halted", int'(halted), 1);
            chk("t5_id", int'(ID), 75);
            chk("t5_ready", int'(dec_if.id_ready), 0);
            if (i == 9) wake = 1'b1;
            cyc();
        end
        wake = 1'b0;
        dec_if.id_valid = 1'b0;
        chk("t5_wake_id", int'(ID), 35);
        chk("t5_wake_take", int'(take), 1);
        chk("t5_wake_halted", int'(halted), 0);

        // T6 illegal, reset mid-wait, soft reset, done on timeout edge
        issue(90);
        chk("t6_illegal_id", int'(ID), 0);
        chk("t6_illegal_fault", int'(fault), 1);
        issue(41);
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk("t6_rst_id", int'(ID), 100);
        chk("t6_rst_ready", int'(dec_if.id_ready), 0);
        repeat (2) cyc();
        chk("t6_rst_back", int'(ID), 35);
        issue(100);
        chk("t6_soft_id", int'(ID), 100);
        cyc();
        chk("t6_soft_hold", int'(ID), 100);
        cyc();
        chk("t6_soft_idle", int'(ID), 35);
        issue(42);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) mem_done = 1'b1;
            cyc();
        end
        mem_done = 1'b0;
        chk("t6_race_take", int'(take), 1);
        chk("t6_race_fault", int'(fault), 0);
        chk("t6_race_id", int'(ID), 42);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            reset = ($urandom % 200) != 0;
            dec_if.id_valid = ($urandom % 4) != 0;
            r = int'($urandom % 20);
            if (r == 0)
                dec_if.decoded_id = 7'd75;
            else if (r == 1)
                dec_if.decoded_id = 7'd100;
            else
                dec_if.decoded_id = 7'($urandom % 128);
            mem_done = ($urandom % 8) == 0;
            wake = ($urandom % 6) == 0;
            cyc();
        end
        reset = 1'b1;
        dec_if.id_valid = 1'b0;
        mem_done = 1'b0;
        wake = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
